// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin stream mux: lock-FSM state encoding,
// default channel count / width and a constant-foldable ceil(log2) helper.
package stream_mux_rr_pkg;

   localparam int DEF_N = 4;
   localparam int DEF_W = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Index width for N channels; callers keep N >= 2 so the result is >= 1.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << r) < v) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr, wrapping modulo N. Shared with other arbiters in the library.
module rr_arbiter
   import stream_mux_rr_pkg::*;
#(
   parameter int  N  = DEF_N,
   localparam int IW = clog2_f(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [IW-1:0] gnt_idx,
   output logic          any_req
);

   int            cand;
   logic [IW-1:0] cand_idx;
   logic          found;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      found      = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) cand = cand - N;
         cand_idx = IW'(cand);
         if (!found && req[cand_idx]) begin
            gnt_onehot[cand_idx] = 1'b1;
            gnt_idx              = cand_idx;
            found                = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with round-robin arbitration. Defining
// STREAM_MUX_LOCK_EN holds the grant on one channel until its last beat.
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter int  N  = DEF_N,
   parameter int  W  = DEF_W,
   localparam int IW = clog2_f(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]  in_valid,
   input  logic [N-1:0]  in_last,
   output logic [N-1:0]  in_ready,
   output logic [W-1:0]  out_data,
   output logic          out_valid,
   output logic          out_last,
   input  logic          out_ready,
   output logic [IW-1:0] out_chan
);

   logic [W-1:0]  out_data_q,  out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q,  out_last_d;
   logic [IW-1:0] out_chan_q,  out_chan_d;
   logic [IW-1:0] rr_ptr_q,    rr_ptr_d;

   logic [N-1:0]  arb_req;
   logic [IW-1:0] arb_ptr;
   logic [N-1:0]  gnt_onehot;
   logic [IW-1:0] gnt_idx;
   logic          any_req;
   logic          load_en;
   logic          xfer;
   logic [W-1:0]  sel_data;
   logic          sel_last;
   logic [IW-1:0] ptr_inc;

`ifdef STREAM_MUX_LOCK_EN
   state_t        state_q, state_d;
   logic [IW-1:0] lock_chan_q, lock_chan_d;

   // While locked only the locked channel may request; a gap becomes a bubble.
   always_comb begin
      arb_req = in_valid;
      arb_ptr = rr_ptr_q;
      if (state_q == ST_LOCKED) begin
         arb_req = in_valid & (N'(1) << lock_chan_q);
         arb_ptr = lock_chan_q;
      end
   end
`else
   assign arb_req = in_valid;
   assign arb_ptr = rr_ptr_q;
`endif

   rr_arbiter #(.N(N)) u_arb (
      .req        (arb_req),
      .ptr        (arb_ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any_req    (any_req)
   );

   assign load_en  = !out_valid_q || out_ready;
   assign xfer     = load_en && any_req && !rst;
   assign sel_data = in_data[gnt_idx*W +: W];
   assign sel_last = in_last[gnt_idx];
   assign ptr_inc  = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign in_ready[gi] = xfer && gnt_onehot[gi];
      end
   endgenerate

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_chan_d  = out_chan_q;
      if (load_en) begin
         out_valid_d = any_req;
         if (any_req) begin
            out_data_d = sel_data;
            out_last_d = sel_last;
            out_chan_d = gnt_idx;
         end
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   always_comb begin
      state_d     = state_q;
      lock_chan_d = lock_chan_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               if (sel_last) begin
                  rr_ptr_d = ptr_inc;
               end else begin
                  state_d     = ST_LOCKED;
                  lock_chan_d = gnt_idx;
               end
            end
         end
         ST_LOCKED: begin
            if (xfer && sel_last) begin
               state_d  = ST_IDLE;
               rr_ptr_d = ptr_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lock_chan_q <= '0;
      end else begin
         state_q     <= state_d;
         lock_chan_q <= lock_chan_d;
      end
   end
`else
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) rr_ptr_d = ptr_inc;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_chan_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_chan_q  <= out_chan_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_chan  = out_chan_q;

endmodule
